sub_bytes_iter: RTL and testbench
=================================

Name: sub_bytes_iter

Overview:
- Iterative AES-128 SubBytes stage; sits directly upstream of shift_row in the round datapath.
- Accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through shared S-box instances.
- Presents the substituted state to shift_row over a valid/ready handshake.
- Trades throughput for area: 4 S-boxes instead of 16 at the default setting.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- CYCLES, 16/LANES, derived localparam giving the number of substitution cycles per state; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream state valid.
- in_ready  out  1  block can accept a state this cycle.
- in_state  in  128  input state; byte 0 = bits [127:120], byte 15 = bits [7:0], column-major (FIPS-197 order).
- out_valid  out  1  substituted state available.
- out_ready  in  1  shift_row side accepts out_state.
- out_state  out  128  substituted state, same byte ordering as in_state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n low asynchronously forces FSM=IDLE, working register=0, counter=0, out_valid=0, busy=0, out_state=0. in_ready=1 once rst_n is high.
- Reset asserted mid-RUN or mid-DONE aborts the state in flight; nothing is emitted after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load in_state into the working register, counter=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, bytes counter*LANES .. counter*LANES+LANES-1 (byte index from MSB) are replaced by S(byte); all other bytes are held.
  - counter increments by 1 each cycle.
  - On counter==CYCLES-1, the last group is written and the FSM goes to DONE.
- DONE:
  - out_valid=1; out_state is the working register.
  - out_state stays stable while out_valid&&!out_ready.
  - in_ready = out_ready, so a pass-through accept is allowed.
  - out_ready=1 with in_valid=1: emit the current state and load the new in_state on the same edge, then go to RUN.
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=0: remain in DONE.
- Latency and throughput:
  - Accept at edge N gives out_valid=1 after edge N+CYCLES (4 cycles at LANES=4).
  - Sustained throughput is one state per CYCLES+1 cycles.
- Counter:
  - Width is $clog2(CYCLES), minimum 1.
  - Never wraps past CYCLES-1; it is reset to 0 on every load.
- Other rules:
  - in_state is ignored whenever in_ready=0; changes there must not disturb an operation in flight.
  - S-box output is exactly the FIPS-197 forward S-box; no pipeline register inside the S-box.
  - out_state is driven directly from the working register, so no combinational path from in_state to out_state.

Decomposition:
- Package aes_pkg holds:
  - typedef byte_t (logic [7:0]);
  - typedef state_t (logic [127:0]);
  - constant SBOX[256] array;
  - function sbox(byte_t) returning byte_t;
  - FSM enum sb_state_e {IDLE, RUN, DONE}.
- One natural sub-module: aes_sbox, combinational, 8-bit in and 8-bit out using aes_pkg::sbox. It is instantiated LANES times via generate, and is reused by the key-expansion block later.

Test Plan:
- Zero and ones states:
  - in_state=128'h0 -> out_state=128'h6363...63 (16 bytes of 63).
  - in_state=all FF -> out_state=all 16.
  - For both, out_valid rises exactly 4 cycles after the accept edge at LANES=4.
- FIPS-197 Appendix B round 1:
  - in_state=193de3bea0f4e22b9ac68d2ae9f84808 -> out_state=d42711aee0bf98f1b8b45de51e415230.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, out_state is unchanged, in_ready=0.
  - Raise out_ready -> one transfer only.
- Back-to-back:
  - in_valid held high with 3 states (00.., FF.., the Appendix B vector) and out_ready=1 -> three outputs in order, spaced 5 cycles apart, no state dropped or duplicated.
- Reset mid-RUN:
  - Assert rst_n=0 for 1 cycle two cycles after an accept -> all outputs go to 0 immediately, the FSM returns to IDLE, and no out_valid pulse follows.
  - The next input is then processed correctly.
- Parameter sweep:
  - Repeat the Appendix B vector with LANES=1, LANES=16 and LANES=2 -> identical out_state, with latency of 16, 1 and 8 cycles respectively.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, the forward S-box table and the SubBytes FSM encoding.
// Used by the SubBytes stage and by later blocks such as key expansion.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sb_state_e;

    // FIPS-197 forward S-box, indexed by the input byte
    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle between the round datapath and the SubBytes stage:
// an accept side (in_*) and a present side (out_*) toward shift_row.
interface sub_bytes_iter_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/aes_sbox.sv
// Purely combinational forward S-box lookup; no register inside so it can be
// dropped into any lane or into key expansion without changing timing.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t data,
    output byte_t result
);

    assign result = sbox(data);

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: one 128-bit state is substituted LANES bytes per cycle
// through shared S-boxes, then held for shift_row until it is taken.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sub_bytes_iter_if.slave  bus,
    output logic             busy
);

    localparam int CYCLES = 16 / LANES;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    sb_state_e       state;
    sb_state_e       next_state;
    state_t          work;
    state_t          run_work;
    logic [CW-1:0]   cnt;
    logic            in_ready;
    logic            load;
    byte_t           lane_in  [LANES];
    byte_t           lane_out [LANES];
    byte_t           cand     [LANES][CYCLES];

    // Each lane picks its byte of the current group; byte 0 is the MSB byte.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        for (genvar c = 0; c < CYCLES; c++) begin : g_cand
            assign cand[g][c] = work[127 - 8 * (c * LANES + g) -: 8];
        end
        if (CYCLES == 1) begin : g_single
            assign lane_in[g] = cand[g][0];
        end else begin : g_multi
            assign lane_in[g] = cand[g][cnt];
        end
        aes_sbox u_sbox (
            .data   (lane_in[g]),
            .result (lane_out[g])
        );
    end

    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign run_work[127 - 8 * b -: 8] = (cnt == CW'(b / LANES)) ?
                                            lane_out[b % LANES] :
                                            work[127 - 8 * b -: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In DONE the upstream may be accepted on the same edge the result leaves.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) next_state = RUN;
            end
            RUN: begin
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready) next_state = bus.in_valid ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign load = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (load) begin
            work <= bus.in_state;
            cnt  <= '0;
        end else if (state == RUN) begin
            work <= run_work;
            if (cnt != LAST) cnt <= cnt + CW'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.out_state = work;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter at LANES = 4, 1, 16 and 2, checked against a
// GF(2^8) inverse + affine model of SubBytes and a transaction-level timing model.
module tb_sub_bytes_iter;
    import aes_pkg::*;

    localparam state_t ZEROS    = '0;
    localparam state_t ONES     = '1;
    localparam state_t SIXTYTHREES = {16{8'h63}};
    localparam state_t SIXTEENS = {16{8'h16}};
    localparam state_t APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam state_t APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam int     LATENCY [4] = '{4, 16, 1, 8};

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   in_valid  [4];
    state_t in_state  [4];
    logic   out_ready [4];
    logic   in_ready  [4];
    logic   out_valid [4];
    state_t out_state [4];
    logic   busy      [4];

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    byte_t  sb_model [256];
    logic   pend       [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    state_t pend_state [4];
    int     pend_edge  [4];
    int     xfer_cnt   [4] = '{0, 0, 0, 0};
    int     xfer_log   [$];
    logic   mon_ov;
    logic   mon_rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int L = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 16 : 2;
        sub_bytes_iter_if bus ();
        assign bus.in_valid  = in_valid[k];
        assign bus.in_state  = in_state[k];
        assign bus.out_ready = out_ready[k];
        assign in_ready[k]   = bus.in_ready;
        assign out_valid[k]  = bus.out_valid;
        assign out_state[k]  = bus.out_state;
        sub_bytes_iter #(.LANES(L)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus),
            .busy  (busy[k])
        );
    end

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic byte_t affine(input byte_t x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            byte_t inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(byte_t'(x), byte_t'(y)) == 8'h01) inv = byte_t'(y);
            end
            sb_model[x] = affine(inv);
        end
    endtask

    function automatic state_t sub_state(input state_t s);
        state_t r;
        for (int i = 0; i < 16; i++) r[8 * i +: 8] = sb_model[s[8 * i +: 8]];
        return r;
    endfunction

    task automatic check_bit(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d got=%0b want=%0b cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    task automatic check_state(input string name, input int k, input state_t act, input state_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d got=%h want=%h cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d got=%0d want=%0d cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    // Transaction model: a state accepted at edge N must be presented from edge
    // N+latency until taken; busy covers exactly the accepted-not-taken window.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) pend[k] = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                mon_ov  = pend[k] && (cyc >= pend_edge[k] + LATENCY[k]);
                mon_rdy = !pend[k] || (mon_ov && out_ready[k]);
                check_bit("out_valid", k, out_valid[k], mon_ov);
                check_bit("busy", k, busy[k], pend[k]);
                check_bit("in_ready", k, in_ready[k], mon_rdy);
                if (mon_ov) check_state("out_state", k, out_state[k], pend_state[k]);
                if (mon_ov && out_ready[k]) begin
                    pend[k] = 1'b0;
                    xfer_cnt[k]++;
                    if (k == 0) xfer_log.push_back(cyc + 1);
                end
                if (in_valid[k] && mon_rdy) begin
                    pend[k]       = 1'b1;
                    pend_state[k] = sub_state(in_state[k]);
                    pend_edge[k]  = cyc + 1;
                end
            end
        end
    end

    task automatic applyStimulus(input int k, input state_t s);
        logic fired = 1'b0;
        in_valid[k] = 1'b1;
        in_state[k] = s;
        for (int n = 0; n < 100 && !fired; n++) begin
            @(negedge clk);
            fired = in_ready[k];
            @(posedge clk);
            #1;
        end
        if (!fired) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout dut%0d got=no_accept want=accept cyc=%0d", k, cyc);
        end
    endtask

    task automatic drop_valid(input int k);
        in_valid[k] = 1'b0;
        in_state[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic checkOutput(input int k, input state_t exp, input int exp_lat, input string name);
        int   start = cyc;
        logic got   = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = out_valid[k];
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout dut%0d got=no_out_valid want=out_valid cyc=%0d", name, k, cyc);
        end else begin
            check_state(name, k, out_state[k], exp);
            if (exp_lat >= 0) check_int({name, "_latency"}, k, cyc - start, exp_lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0;
        int seen;
        build_model();
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b1;
        end

        check_state("model_zero", -1, sub_state(ZEROS), SIXTYTHREES);
        check_state("model_ones", -1, sub_state(ONES), SIXTEENS);
        check_state("model_appb", -1, sub_state(APPB_IN), APPB_OUT);

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_bit("reset_out_valid", k, out_valid[k], 1'b0);
            check_bit("reset_busy", k, busy[k], 1'b0);
            check_state("reset_out_state", k, out_state[k], ZEROS);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) check_bit("post_reset_in_ready", k, in_ready[k], 1'b1);

        $display("[TB] zero, ones and Appendix B vectors at LANES=4");
        applyStimulus(0, ZEROS);
        drop_valid(0);
        checkOutput(0, SIXTYTHREES, 4, "zero");
        applyStimulus(0, ONES);
        drop_valid(0);
        checkOutput(0, SIXTEENS, 4, "ones");
        applyStimulus(0, APPB_IN);
        drop_valid(0);
        checkOutput(0, APPB_OUT, 4, "appb");

        $display("[TB] backpressure");
        out_ready[0] = 1'b0;
        applyStimulus(0, ONES);
        drop_valid(0);
        checkOutput(0, SIXTEENS, 4, "bp_first");
        repeat (3) begin
            @(negedge clk);
            check_bit("bp_hold_valid", 0, out_valid[0], 1'b1);
            check_state("bp_hold_state", 0, out_state[0], SIXTEENS);
            check_bit("bp_hold_in_ready", 0, in_ready[0], 1'b0);
            @(posedge clk);
            #1;
        end
        n0 = xfer_cnt[0];
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("bp_released_valid", 0, out_valid[0], 1'b0);
        check_int("bp_transfers", 0, xfer_cnt[0], n0 + 1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back with pass-through accept");
        xfer_log.delete();
        applyStimulus(0, ZEROS);
        applyStimulus(0, ONES);
        applyStimulus(0, APPB_IN);
        drop_valid(0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check_int("b2b_count", 0, xfer_log.size(), 3);
        if (xfer_log.size() == 3) begin
            check_int("b2b_spacing1", 0, xfer_log[1] - xfer_log[0], 5);
            check_int("b2b_spacing2", 0, xfer_log[2] - xfer_log[1], 5);
        end

        $display("[TB] reset during RUN");
        applyStimulus(0, APPB_IN);
        drop_valid(0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_bit("midreset_out_valid", k, out_valid[k], 1'b0);
            check_bit("midreset_busy", k, busy[k], 1'b0);
            check_state("midreset_out_state", k, out_state[k], ZEROS);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_bit("after_reset_in_ready", 0, in_ready[0], 1'b1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
            @(posedge clk);
            #1;
        end
        check_int("no_pulse_after_reset", 0, seen, 0);
        applyStimulus(0, ZEROS);
        drop_valid(0);
        checkOutput(0, SIXTYTHREES, 4, "after_reset_zero");

        $display("[TB] lane-count sweep");
        for (int k = 1; k < 4; k++) begin
            applyStimulus(k, APPB_IN);
            drop_valid(k);
            checkOutput(k, APPB_OUT, LATENCY[k], "sweep_appb");
        end
        applyStimulus(3, ONES);
        drop_valid(3);
        checkOutput(3, SIXTEENS, 8, "sweep_ones");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
